// File: rtl/ddr3_device_model.sv
// Responder model of an MT41K256M16 command interface. It decodes RAS/CAS/WE
// commands, tracks the open row of each of the 8 banks, and stores write data
// in a reduced array indexed by {bank, low row bits, low column bits}.
// Read data is returned on ddr3_dq exactly CL cycles after the READ is on the
// pins. Protocol violations by the controller raise sticky err bits:
//   err[0] cke raised before ddr3_reset_n was high for TRST cycles
//   err[1] MRS/REF issued while a bank is open
//   err[2] ACT to a bank that is already open
//   err[3] READ/WRITE to a closed bank
//   err[4] non-NOP command with cke high outside the operational state
//   err[5] WRITE issued while this model is driving ddr3_dq
// The bus has no valid/ready handshake: every command is accepted in the cycle
// it is sampled, and read data is driven for exactly one cycle per READ.
module ddr3_device_model #(
  parameter int CL       = 2,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int TRST     = 22000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ddr3_reset_n,
  input  logic        ddr3_cke,
  input  logic        ddr3_ras_n,
  input  logic        ddr3_cas_n,
  input  logic        ddr3_we_n,
  input  logic [2:0]  ddr3_ba,
  input  logic [14:0] ddr3_addr,
  input  logic [1:0]  ddr3_dm,
  inout  wire  [15:0] ddr3_dq,
  output logic        ready,
  output logic [7:0]  open_banks,
  output logic [5:0]  err,
  output logic [1:0]  o_dbg_state
);

  localparam int IDX_W = 3 + ROW_BITS + COL_BITS;
  localparam int CNT_W = $clog2(TRST + 1) + 1;
  localparam logic [CNT_W-1:0] TRST_C  = CNT_W'(TRST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic [7:0]       r_open;
  logic [14:0]      r_row [8];
  logic [5:0]       r_err;
  logic [CL-1:0]    r_pv;
  logic [15:0]      r_pd [CL];
  logic [15:0]      r_mem [2**IDX_W];

  logic [2:0]          w_cmd;
  logic                w_decode;
  logic                w_bank_open;
  logic [ROW_BITS-1:0] w_row_lo;
  logic [IDX_W-1:0]    w_idx;
  logic                w_is_wr;
  logic                w_is_rd;
  logic                w_wr_en;
  logic                w_drive;
  logic [15:0]         w_mem_q;
  logic                w_unused_row;

  assign w_cmd       = {ddr3_ras_n, ddr3_cas_n, ddr3_we_n};
  // Commands are honoured only when operational, clocked, and not being reset.
  assign w_decode    = (r_state == S_READY) && ddr3_cke && ddr3_reset_n;
  assign w_bank_open = r_open[ddr3_ba];
  assign w_row_lo    = r_row[ddr3_ba][ROW_BITS-1:0];
  assign w_idx       = {ddr3_ba, w_row_lo, ddr3_addr[COL_BITS-1:0]};
  assign w_is_wr     = w_decode && (w_cmd == CMD_WR);
  assign w_is_rd     = w_decode && (w_cmd == CMD_RD);
  assign w_wr_en     = w_is_wr && w_bank_open;
  assign w_drive     = r_pv[CL-1];
  assign w_mem_q     = r_mem[w_idx];

  assign ddr3_dq     = w_drive ? r_pd[CL-1] : 16'hzzzz;
  assign ready       = r_ready;
  assign open_banks  = r_open;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // Upper row bits are kept per bank but alias onto the same array rows.
  always_comb begin
    w_unused_row = 1'b0;
    for (int b = 0; b < 8; b++) begin
      w_unused_row = w_unused_row ^ (^r_row[b][14:ROW_BITS]);
    end
  end

  // Data array: per-byte masked write in the command cycle, never cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (!ddr3_dm[0]) r_mem[w_idx][7:0]  <= ddr3_dq[7:0];
      if (!ddr3_dm[1]) r_mem[w_idx][15:8] <= ddr3_dq[15:8];
    end
  end

  // Read pipeline: CL-deep shift of {valid, data}; flushed on device reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pv <= '0;
      for (int i = 0; i < CL; i++) r_pd[i] <= '0;
    end else if (!ddr3_reset_n) begin
      r_pv <= '0;
    end else begin
      for (int i = CL - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
      r_pv[0] <= w_is_rd;
      r_pd[0] <= w_bank_open ? w_mem_q : 16'hDEAD;
    end
  end

  // Init FSM, bank tracking and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_open  <= '0;
      r_err   <= '0;
      for (int b = 0; b < 8; b++) r_row[b] <= '0;
    end else begin
      r_ready <= (r_state == S_READY) && ddr3_reset_n;
      if (ddr3_cke && (w_cmd != CMD_NOP) && (r_state != S_READY)) r_err[4] <= 1'b1;
      if (!ddr3_reset_n) begin
        r_state <= S_RST;
        r_open  <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_RST: begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
          S_WAIT: begin
            if (ddr3_cke) begin
              r_state <= S_READY;
              if (r_cnt < TRST_C) r_err[0] <= 1'b1;
            end else if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_READY: begin
            if (ddr3_cke) begin
              case (w_cmd)
                CMD_MRS, CMD_REF: begin
                  if (|r_open) r_err[1] <= 1'b1;
                end
                CMD_ACT: begin
                  if (w_bank_open) r_err[2] <= 1'b1;
                  r_open[ddr3_ba] <= 1'b1;
                  r_row[ddr3_ba]  <= ddr3_addr;
                end
                CMD_PRE: begin
                  if (ddr3_addr[10]) r_open <= '0;
                  else               r_open[ddr3_ba] <= 1'b0;
                end
                CMD_WR, CMD_RD: begin
                  if ((w_cmd == CMD_WR) && w_drive) r_err[5] <= 1'b1;
                  if (!w_bank_open)        r_err[3] <= 1'b1;
                  else if (ddr3_addr[10])  r_open[ddr3_ba] <= 1'b0;
                end
                default: ;
              endcase
            end
          end
          default: r_state <= S_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_device_model.sv
// Bench for ddr3_device_model: directed command sequences, a behavioural model
// that predicts ready/open_banks/err/dq every cycle, and literal spot checks.
// The released bus is pulled high, so an idle dq reads as 16'hFFFF.
module tb_ddr3_device_model;

  localparam int CL       = 2;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 6;
  localparam int TRST     = 22000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn    = 1'b0;
  logic        rst_n_dev = 1'b0;
  logic        cke       = 1'b0;
  logic        ras_n     = 1'b1;
  logic        cas_n     = 1'b1;
  logic        we_n      = 1'b1;
  logic [2:0]  ba        = '0;
  logic [14:0] addr      = '0;
  logic [1:0]  dm        = 2'b11;
  logic [15:0] tb_dq_drv = '0;
  logic        tb_dq_en  = 1'b0;
  wire  [15:0] dq;
  logic        ready;
  logic [7:0]  open_banks;
  logic [5:0]  err;
  logic [1:0]  dbg_state;

  assign dq = tb_dq_en ? tb_dq_drv : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  ddr3_device_model #(
    .CL(CL), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .TRST(TRST)
  ) dut (
    .clk(clk), .resetn(resetn), .ddr3_reset_n(rst_n_dev), .ddr3_cke(cke),
    .ddr3_ras_n(ras_n), .ddr3_cas_n(cas_n), .ddr3_we_n(we_n),
    .ddr3_ba(ba), .ddr3_addr(addr), .ddr3_dm(dm), .ddr3_dq(dq),
    .ready(ready), .open_banks(open_banks), .err(err), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // index of the next rising edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 = held in device reset, 1 = counting reset-high time, 2 = operational.
  int          m_phase      = 0;
  int          m_wait_edge  = 0;
  int          m_ready_edge = 0;
  logic [7:0]  m_open       = '0;
  logic [14:0] m_row [8];
  logic [5:0]  m_err        = '0;
  logic [15:0] m_mem [int];          // survives every reset, like the device array
  logic [15:0] exp_q [$];            // expected read words, in order
  int          due_q [$];            // edge after which each word is on the bus
  logic [15:0] m_bus [int];          // what the device drives after a given edge

  task automatic model_reset();
    m_phase = 0;
    m_open  = '0;
    m_err   = '0;
    exp_q.delete();
    due_q.delete();
    m_bus.delete();
  endtask

  task automatic model_cmd(input int k, input logic [2:0] c);
    int b, idx;
    logic op, busy;
    logic [15:0] bus, w, r;
    b   = int'(ba);
    op  = m_open[b];
    idx = b * (1 << (ROW_BITS + COL_BITS))
        + (int'(m_row[b]) % (1 << ROW_BITS)) * (1 << COL_BITS)
        + int'(addr) % (1 << COL_BITS);
    case (c)
      3'b000, 3'b001: if (m_open != 0) m_err[1] = 1'b1;
      3'b011: begin
        if (op) m_err[2] = 1'b1;
        m_open[b] = 1'b1;
        m_row[b]  = addr;
      end
      3'b010: if (addr[10]) m_open = '0; else m_open[b] = 1'b0;
      3'b100: begin
        busy = m_bus.exists(k - 1);
        if (busy) m_err[5] = 1'b1;
        if (!op) m_err[3] = 1'b1;
        else begin
          bus = tb_dq_en ? tb_dq_drv : (busy ? m_bus[k-1] : 16'hFFFF);
          w = m_mem.exists(idx) ? m_mem[idx] : 16'hxxxx;
          if (!dm[0]) w[7:0]  = bus[7:0];
          if (!dm[1]) w[15:8] = bus[15:8];
          m_mem[idx] = w;
          if (addr[10]) m_open[b] = 1'b0;
        end
      end
      3'b101: begin
        if (!op) begin
          m_err[3] = 1'b1;
          r = 16'hDEAD;
        end else begin
          r = m_mem.exists(idx) ? m_mem[idx] : 16'hxxxx;
          if (addr[10]) m_open[b] = 1'b0;
        end
        exp_q.push_back(r);
        due_q.push_back(k + CL - 1);
        m_bus[k + CL - 1] = r;
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input int k);
    logic [2:0] c;
    c = {ras_n, cas_n, we_n};
    if (cke && (c != 3'b111) && (m_phase != 2)) m_err[4] = 1'b1;
    if (!rst_n_dev) begin
      m_phase = 0;
      m_open  = '0;
      while (due_q.size() > 0 && due_q[$] >= k) begin
        void'(due_q.pop_back());
        void'(exp_q.pop_back());
      end
      for (int j = k; j < k + CL; j++) if (m_bus.exists(j)) m_bus.delete(j);
    end else if (m_phase == 0) begin
      m_phase     = 1;
      m_wait_edge = k;
    end else if (m_phase == 1) begin
      if (cke) begin
        if (k - m_wait_edge - 1 < TRST) m_err[0] = 1'b1;
        m_phase      = 2;
        m_ready_edge = k + 1;
      end
    end else if (cke) begin
      model_cmd(k, c);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else         model_step(cyc);
  end

  // ---------------- scoreboard compare ----------------
  task automatic compare_outputs(input int k);
    logic [15:0] e;
    logic er;
    er = (m_phase == 2) && (k >= m_ready_edge);
    chk("ready", ready, er);
    chk("open_banks", open_banks, m_open);
    chk("err", err, m_err);
    if (due_q.size() > 0 && due_q[0] == k) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      if (!$isunknown(e)) chk("dq_read", dq, e);
    end else if (!tb_dq_en) begin
      chk("dq_idle", dq, 16'hFFFF);
    end
  endtask

  always @(negedge clk) compare_outputs(cyc - 1);

  // ---------------- driver tasks ----------------
  task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a,
                     input logic [15:0] d, input logic [1:0] m, input logic drv);
    {ras_n, cas_n, we_n} = c;
    ba = b; addr = a; tb_dq_drv = d; dm = m; tb_dq_en = drv;
    @(posedge clk);
    #1;
    {ras_n, cas_n, we_n} = 3'b111;
    tb_dq_en = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) cmd(3'b111, 3'd0, 15'd0, 16'd0, 2'b11, 1'b0);
  endtask

  task automatic act(input logic [2:0] b, input logic [14:0] row);
    cmd(3'b011, b, row, 16'd0, 2'b11, 1'b0);
  endtask

  task automatic wr(input logic [2:0] b, input int col, input logic [15:0] d,
                    input logic [1:0] m, input logic drv);
    cmd(3'b100, b, 15'(col), d, m, drv);
  endtask

  task automatic rd(input logic [2:0] b, input int col, input logic ap);
    cmd(3'b101, b, 15'(col) | (ap ? 15'h400 : 15'h0), 16'd0, 2'b11, 1'b0);
  endtask

  task automatic power_up(input int hold, input logic exp_e0);
    cke = 1'b0;
    rst_n_dev = 1'b1;
    nop(hold);
    cke = 1'b1;
    nop(1);
    chk("pwr_ready_lag", ready, 1'b0);
    nop(1);
    chk("pwr_ready", ready, 1'b1);
    chk("pwr_err0", err[0], exp_e0);
  endtask

  logic [15:0] pat [4];

  // ---------------- directed sequence ----------------
  initial begin
    pat[0] = 16'hC0DE; pat[1] = 16'h5EED; pat[2] = 16'h0B0E; pat[3] = 16'h7A11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_open", open_banks, 8'h00);
    chk("rst_err", err, 6'h00);
    chk("rst_dq", dq, 16'hFFFF);
    chk("rst_state", dbg_state, 2'd0);
    resetn = 1'b1;
    nop(5);

    // Full power-up with a legal reset-high time.
    power_up(22100, 1'b0);
    chk("pwr_err_clean", err, 6'h00);

    // Basic write / precharge / reopen / read.
    act(3'd3, 15'd5);
    chk("act_open", open_banks, 8'h08);
    wr(3'd3, 7, 16'hA55A, 2'b00, 1'b1);
    cmd(3'b010, 3'd0, 15'h400, 16'd0, 2'b11, 1'b0);
    chk("pre_all_open", open_banks, 8'h00);
    act(3'd3, 15'd5);
    rd(3'd3, 7, 1'b0);
    chk("rd_early", dq, 16'hFFFF);
    nop(1);
    chk("rd_data", dq, 16'hA55A);
    nop(1);
    chk("rd_after", dq, 16'hFFFF);

    // Byte mask: low byte masked keeps the stored low byte.
    wr(3'd3, 8, 16'hFFFF, 2'b00, 1'b1);
    wr(3'd3, 8, 16'h1234, 2'b01, 1'b1);
    rd(3'd3, 8, 1'b0);
    nop(1);
    chk("dm_merge", dq, 16'h12FF);
    nop(2);

    // Back-to-back reads of four distinct words.
    for (int i = 0; i < 4; i++) wr(3'd3, i, pat[i], 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd(3'd3, i, 1'b0);
      if (i == 0) chk("b2b_before", dq, 16'hFFFF);
      else        chk("b2b_word", dq, {16'h0, pat[i-1]});
    end
    nop(1);
    chk("b2b_last", dq, pat[3]);
    nop(1);
    chk("b2b_after", dq, 16'hFFFF);

    // Closed-bank read and double activate.
    rd(3'd2, 0, 1'b0);
    chk("closed_rd_err", err, 6'b001000);
    nop(1);
    chk("closed_rd_dq", dq, 16'hDEAD);
    act(3'd1, 15'd9);
    act(3'd1, 15'd9);
    chk("double_act_err", err, 6'b001100);

    // MRS with banks open, then ZQ and REF with all banks closed.
    cmd(3'b000, 3'd0, 15'd0, 16'd0, 2'b11, 1'b0);
    chk("mrs_open_err", err, 6'b001110);
    cmd(3'b010, 3'd0, 15'h400, 16'd0, 2'b11, 1'b0);
    cmd(3'b110, 3'd0, 15'd0, 16'd0, 2'b11, 1'b0);
    cmd(3'b001, 3'd0, 15'd0, 16'd0, 2'b11, 1'b0);
    chk("ref_closed_err", err, 6'b001110);

    // Read with auto-precharge closes the bank.
    act(3'd3, 15'd5);
    rd(3'd3, 7, 1'b1);
    chk("ap_closed", open_banks, 8'h00);
    nop(1);
    chk("ap_data", dq, 16'hA55A);

    // WRITE while the model drives the bus stores the bus value.
    act(3'd3, 15'd5);
    rd(3'd3, 7, 1'b0);
    nop(1);
    wr(3'd3, 20, 16'h0000, 2'b00, 1'b0);
    chk("collide_err", err, 6'b101110);
    rd(3'd3, 20, 1'b0);
    nop(1);
    chk("collide_data", dq, 16'hA55A);

    // Device reset keeps err; command with cke during reset flags err[4].
    rst_n_dev = 1'b0;
    nop(1);
    chk("devrst_open", open_banks, 8'h00);
    chk("devrst_ready", ready, 1'b0);
    act(3'd0, 15'd0);
    chk("devrst_err", err, 6'b111110);
    power_up(1000, 1'b1);

    // Asynchronous reset during an in-flight read.
    act(3'd3, 15'd5);
    rd(3'd3, 7, 1'b0);
    @(posedge clk);
    #2;
    chk("inflight_driven", dq, 16'hA55A);
    resetn = 1'b0;
    #1;
    chk("async_dq", dq, 16'hFFFF);
    chk("async_open", open_banks, 8'h00);
    chk("async_err", err, 6'h00);
    @(posedge clk);
    #1;
    rst_n_dev = 1'b0;
    cke = 1'b0;
    resetn = 1'b1;
    nop(3);
    power_up(1000, 1'b1);
    chk("reinit_err", err, 6'b000001);

    // Array contents survive every reset.
    act(3'd3, 15'd5);
    rd(3'd3, 7, 1'b0);
    nop(1);
    chk("keep_a55a", dq, 16'hA55A);
    rd(3'd3, 8, 1'b0);
    nop(1);
    chk("keep_12ff", dq, 16'h12FF);
    nop(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
